operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; integer multiple of 8, minimum 8.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream byte present.
REQ-005 SHALL have port: in_ready  output  1  loader accepts byte this cycle.
REQ-006 SHALL have port: in_data  input  8  operand byte.
REQ-007 SHALL have port: flush  input  1  synchronous discard of partial load.
REQ-008 SHALL have port: a  output  WIDTH  first operand to comparator/ALU.
REQ-009 SHALL have port: b  output  WIDTH  second operand to comparator/ALU.
REQ-010 SHALL have port: op_valid  output  1  a and b complete and stable.
REQ-011 SHALL have port: op_ready  input  1  downstream consumes operand pair.

Function
REQ-012 SHALL implement FSM states LOAD_A, LOAD_B, PRESENT; byte counter of log2(WIDTH/8) bits (N = WIDTH/8 bytes per operand).
REQ-013 SHALL drive in_ready = 1 in LOAD_A and LOAD_B and 0 in PRESENT; in_ready SHALL be 0 while rst is high.
REQ-014 SHALL count a transfer only when in_valid and in_ready are both 1 at a rising edge.
REQ-015 SHALL place transfer k (k = 0..N-1) of an operand into bits [8k+7:8k] (little-endian); other bytes unchanged.
REQ-016 SHALL move LOAD_A -> LOAD_B on the Nth A transfer and LOAD_B -> PRESENT on the Nth B transfer, resetting counter to 0 each time.
REQ-017 SHALL assert op_valid exactly while in PRESENT: first asserted the cycle after the final B byte's edge.
REQ-018 SHALL hold a and b constant throughout PRESENT, regardless of in_valid/in_data.
REQ-019 SHALL move PRESENT -> LOAD_A on an edge where op_valid and op_ready are both 1; op_valid low the next cycle.
REQ-020 SHALL retain a and b after handoff until overwritten byte-by-byte by the next load.
REQ-021 SHALL ignore op_ready outside PRESENT; op_valid SHALL not depend combinationally on op_ready.
REQ-022 SHALL give flush priority over any transfer or handoff on the same edge: state -> LOAD_A, counter -> 0, op_valid -> 0, a/b unchanged, byte on that edge discarded.
REQ-023 SHALL tolerate in_valid gaps of any length without changing state or counter.
REQ-024 SHALL achieve maximum throughput of one operand pair per 2N+1 cycles (9 for WIDTH=32) with in_valid and op_ready held high.

Reset
REQ-025 SHALL, while rst is high, force state LOAD_A, counter 0, a = 0, b = 0, op_valid = 0, independent of clk.
REQ-026 SHALL accept the first byte on the first rising edge with rst low and in_valid high; reset mid-load SHALL discard all partial bytes.

Structure
REQ-027 SHALL take the FSM state encoding (LOAD_A=0, LOAD_B=1, PRESENT=2) and the BYTE_W=8 constant from the shared ALU package.
REQ-028 SHALL instantiate one sub-module byte_assembler (WIDTH register, byte-lane write enable plus byte index), once for a and once for b.
REQ-029 SHALL contain no arithmetic or comparison on a/b; operands go unmodified to the comparator.

Verification
REQ-030 SHALL cover: bytes 09 00 00 00 02 00 00 00 back-to-back, op_ready=1 -> op_valid one cycle after 8th transfer, a=0x00000009, b=0x00000002, attached comparator output 1, op_valid low next cycle.
REQ-031 SHALL cover: load a=b=0x00000808, op_ready low 5 cycles with in_valid high and in_data random -> op_valid held, in_ready 0, a/b stable, handoff on first op_ready=1 edge.
REQ-032 SHALL cover: 2 A bytes (AA BB), flush pulse, then 01 00 00 00 FF FF FF FF -> a=0x00000001, b=0xFFFFFFFF, comparator output 0.
REQ-033 SHALL cover: rst asserted asynchronously mid-clock after 3 B bytes -> a=b=0, op_valid=0 immediately; next 8 bytes form a fresh pair.
REQ-034 SHALL cover: two pairs streamed with in_valid and op_ready tied high -> op_valid pulses 9 cycles apart, second pair correct.
REQ-035 SHALL cover: flush and final B byte on same edge -> no op_valid, state LOAD_A, counter 0.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared ALU constants and loader state encoding
package operand_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/operand_loader_byte_assembler.sv
// byte_assembler: operand register written one byte lane at a time
module byte_assembler
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IW-1:0]    idx,
    input  logic [7:0]       din,
    output logic [WIDTH-1:0] q
);

    // write the addressed lane, all other lanes hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (we)
            q[idx*BYTE_W +: BYTE_W] <= din;
    end

endmodule

// File: rtl/operand_loader.sv
// operand_loader: assembles two little-endian operands from a byte stream
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             flush,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             op_valid,
    input  logic             op_ready
);

    localparam int N  = WIDTH / BYTE_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state, state_n;
    logic [IW-1:0] cnt, cnt_n;
    logic          xfer, last, we_a, we_b;

    assign in_ready = !rst && (state != PRESENT);
    assign op_valid = (state == PRESENT);
    assign xfer     = in_valid && in_ready;
    assign last     = (cnt == LAST);
    assign we_a     = xfer && !flush && (state == LOAD_A);
    assign we_b     = xfer && !flush && (state == LOAD_B);

    // state and byte counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD_A;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next state: flush wins over transfers and handoff
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (flush) begin
            state_n = LOAD_A;
            cnt_n   = '0;
        end else if (state == PRESENT) begin
            state_n = op_ready ? LOAD_A : PRESENT;
        end else if (xfer) begin
            cnt_n = last ? '0 : cnt + 1'b1;
            if (last)
                state_n = (state == LOAD_A) ? LOAD_B : PRESENT;
        end
    end

    byte_assembler #(.WIDTH(WIDTH), .IW(IW)) u_asm_a (
        .clk (clk),
        .rst (rst),
        .we  (we_a),
        .idx (cnt),
        .din (in_data),
        .q   (a)
    );

    byte_assembler #(.WIDTH(WIDTH), .IW(IW)) u_asm_b (
        .clk (clk),
        .rst (rst),
        .we  (we_b),
        .idx (cnt),
        .din (in_data),
        .q   (b)
    );

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: scoreboard bench for operand_loader
module tb_operand_loader;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [7:0]  in_data = 0;
    logic        flush = 0;
    logic [31:0] a, b;
    logic        op_valid;
    logic        op_ready = 0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [63:0] sb[$];
    int rises[$];
    logic ov_d = 0;

    operand_loader #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .op_valid (op_valid),
        .op_ready (op_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] d);
        int n = 0;
        in_valid = 1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic put_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) put(w[8*i +: 8]);
    endtask

    // handoff monitor: pops the expected pair whenever a handoff edge is coming
    always @(negedge clk) begin
        if (op_valid && !ov_d) rises.push_back(cyc);
        ov_d <= op_valid;
        if (!rst && op_valid && op_ready && !flush) begin
            if (sb.size() == 0) check("sb_empty_pop", 1, 0);
            else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("sb_a", a, e[63:32]);
                check("sb_b", b, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        @(posedge clk); #1;
        rst = 0;

        // back-to-back pair, comparator a>b
        op_ready = 1;
        sb.push_back({32'h9, 32'h2});
        put_word(32'h0000_0009);
        put_word(32'h0000_0002);
        check("t1_op_valid", op_valid, 1);
        check("t1_a", a, 32'h9);
        check("t1_b", b, 32'h2);
        check("t1_cmp", a > b, 1);
        @(posedge clk); #1;
        check("t1_op_valid_low", op_valid, 0);

        // backpressure hold
        op_ready = 0;
        sb.push_back({32'h808, 32'h808});
        put_word(32'h0000_0808);
        put_word(32'h0000_0808);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_data  = 8'($urandom);
            @(negedge clk);
            check("t2_op_valid", op_valid, 1);
            check("t2_in_ready", in_ready, 0);
            check("t2_a", a, 32'h808);
            check("t2_b", b, 32'h808);
            @(posedge clk); #1;
        end
        in_valid = 0;
        op_ready = 1;
        @(posedge clk); #1;
        check("t2_handoff", op_valid, 0);

        // flush after partial A
        put(8'hAA);
        put(8'hBB);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        check("t3_a_kept", a, 32'h0000_BBAA);
        check("t3_in_ready", in_ready, 1);
        sb.push_back({32'h1, 32'hFFFF_FFFF});
        put_word(32'h0000_0001);
        put_word(32'hFFFF_FFFF);
        check("t3_a", a, 32'h1);
        check("t3_b", b, 32'hFFFF_FFFF);
        check("t3_cmp", a > b, 0);
        @(posedge clk); #1;

        // async reset mid-load
        put_word(32'h4433_2211);
        put(8'h55); put(8'h66); put(8'h77);
        #2;
        rst = 1;
        #1;
        check("t4_a", a, 0);
        check("t4_b", b, 0);
        check("t4_op_valid", op_valid, 0);
        check("t4_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        sb.push_back({32'h0403_0201, 32'h0807_0605});
        put_word(32'h0403_0201);
        put_word(32'h0807_0605);
        check("t4_fresh_a", a, 32'h0403_0201);
        check("t4_fresh_b", b, 32'h0807_0605);
        @(posedge clk); #1;

        // streaming throughput
        n0 = rises.size();
        begin
            logic [31:0] w[4];
            for (int i = 0; i < 4; i++) w[i] = $urandom;
            sb.push_back({w[0], w[1]});
            sb.push_back({w[2], w[3]});
            for (int i = 0; i < 4; i++) put_word(w[i]);
            check("t5_a2", a, w[2]);
            check("t5_b2", b, w[3]);
        end
        @(posedge clk); #1;
        check("t5_rises", rises.size() - n0, 2);
        if (rises.size() - n0 == 2) check("t5_spacing", rises[n0+1] - rises[n0], 9);

        // flush on final B byte edge
        put_word(32'hDEAD_BEEF);
        put(8'h01); put(8'h02); put(8'h03);
        in_valid = 1;
        in_data  = 8'h04;
        flush    = 1;
        @(posedge clk); #1;
        flush    = 0;
        in_valid = 0;
        check("t6_op_valid", op_valid, 0);
        check("t6_state", dut.state, 0);
        check("t6_cnt", dut.cnt, 0);
        check("t6_b_kept", b[23:0], 24'h030201);
        @(posedge clk); #1;
        check("t6_still_idle", op_valid, 0);
        sb.push_back({32'h1234_5678, 32'h9ABC_DEF0});
        put_word(32'h1234_5678);
        put_word(32'h9ABC_DEF0);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
